lcd_bus_monitor: RTL

LCD_BUS_MONITOR -- requirements
Module: lcd_bus_monitor

---
 rtl/lcd_bus_monitor.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/lcd_bus_monitor.sv
// Passive monitor for a 4-bit HD44780-style LCD bus: registers the bus, validates strobes,
// follows the power-on nibble sequence, assembles bytes and tracks the DDRAM cursor.
module lcd_bus_monitor #(
   parameter int MIN_E_HIGH = 12
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sf_e,
   input  logic       e,
   input  logic       rs,
   input  logic       rw,
   input  logic [3:0] db,
   output logic       byte_valid,
   output logic [7:0] byte_out,
   output logic       byte_is_data,
   output logic [6:0] ddram_addr,
   output logic       init_done,
   output logic       proto_err
);

   typedef enum logic [1:0] {INIT, HI, LO} state_t;

   state_t     state, state_nxt;
   logic       e_q, rs_q, rw_q, sf_e_q;
   logic [3:0] db_q;
   logic [3:0] cnt;
   logic [1:0] idx, idx_nxt;
   logic [3:0] hi_nib, hi_nib_nxt;
   logic       hi_rs, hi_rs_nxt;
   logic       init_nxt, emit, err;
   logic       strobe, live, wide, accept;
   logic [3:0] expect_nib;

   function automatic logic [6:0] next_addr(input logic [6:0] addr, input logic [7:0] b,
                                            input logic is_data);
      logic [6:0] a;
      a = addr;
      if (is_data) begin
         if (addr == 7'h27)      a = 7'h40;
         else if (addr == 7'h67) a = 7'h00;
         else                    a = addr + 7'd1;
      end else if (b[7]) begin
         a = b[6:0];
      end else if (b == 8'h01 || b == 8'h02) begin
         a = 7'h00;
      end
      return a;
   endfunction

   // Strobe width includes the current e_q-high cycle, so cnt+1 is the true width.
   assign strobe     = e_q & ~e;
   assign live       = strobe & ~sf_e_q & ~rw_q;
   assign wide       = (int'(cnt) + 1) >= MIN_E_HIGH;
   assign accept     = live & wide;
   assign expect_nib = (idx == 2'd3) ? 4'h2 : 4'h3;

   // Input registers and e-high counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         e_q    <= 1'b0;
         rs_q   <= 1'b0;
         rw_q   <= 1'b0;
         sf_e_q <= 1'b0;
         db_q   <= 4'h0;
         cnt    <= 4'h0;
      end else begin
         e_q    <= e;
         rs_q   <= rs;
         rw_q   <= rw;
         sf_e_q <= sf_e;
         db_q   <= db;
         if (!e_q)             cnt <= 4'h0;
         else if (cnt != 4'hF) cnt <= cnt + 4'd1;
      end
   end

   always_comb begin
      state_nxt  = state;
      idx_nxt    = idx;
      hi_nib_nxt = hi_nib;
      hi_rs_nxt  = hi_rs;
      init_nxt   = init_done;
      emit       = 1'b0;
      err        = live & ~wide;
      if (accept) begin
         unique case (state)
            INIT: begin
               if (!rs_q && db_q == expect_nib) begin
                  idx_nxt = idx + 2'd1;
                  if (idx == 2'd3) begin
                     init_nxt  = 1'b1;
                     state_nxt = HI;
                  end
               end else begin
                  err     = 1'b1;
                  idx_nxt = (!rs_q && db_q == 4'h3) ? 2'd1 : 2'd0;
               end
            end
            HI: begin
               hi_nib_nxt = db_q;
               hi_rs_nxt  = rs_q;
               state_nxt  = LO;
            end
            LO: begin
               if (rs_q == hi_rs) emit = 1'b1;
               else               err  = 1'b1;
               state_nxt = HI;
            end
            default: state_nxt = INIT;
         endcase
      end
   end

   // FSM state and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= INIT;
         idx          <= 2'd0;
         hi_nib       <= 4'h0;
         hi_rs        <= 1'b0;
         init_done    <= 1'b0;
         byte_valid   <= 1'b0;
         proto_err    <= 1'b0;
         byte_out     <= 8'h00;
         byte_is_data <= 1'b0;
         ddram_addr   <= 7'h00;
      end else begin
         state      <= state_nxt;
         idx        <= idx_nxt;
         hi_nib     <= hi_nib_nxt;
         hi_rs      <= hi_rs_nxt;
         init_done  <= init_nxt;
         byte_valid <= emit;
         proto_err  <= err;
         if (emit) begin
            byte_out     <= {hi_nib, db_q};
            byte_is_data <= hi_rs;
            ddram_addr   <= next_addr(ddram_addr, {hi_nib, db_q}, hi_rs);
         end
      end
   end

endmodule
